qeciphy_tx_slot_scheduler: RTL and testbench
============================================

// Module: qeciphy_tx_slot_scheduler
// PURPOSE
//  Per-cycle TX slot scheduler between the TX boundary generator and the TX framer mux.
//  Classifies each cycle as a FAW, CRC or payload slot from the boundary strobes.
//  Arbitrates payload slots between a control-message stream and a user-data stream,
//  with a bounded control-burst fairness rule, and emits one registered word plus a type code.
// PARAMETERS
//  DATA_W          64  width of data, control and output words
//  MAX_CTRL_BURST  4   max consecutive ctrl grants while data is pending (1..15)
//  STAT_W          32  width of statistics counters (only with QECIPHY_TX_SCHED_STATS_EN)
// PORTS
//  clk_i             in   1       clock
//  rst_n_i           in   1       synchronous reset, active-low
//  enable_i          in   1       scheduler enable (level)
//  faw_boundary_i    in   1       current cycle is a FAW slot
//  crc_boundary_i    in   1       current cycle is a CRC slot
//  data_tdata_i      in   DATA_W  user data word
//  data_tvalid_i     in   1       user data valid
//  data_tready_o     out  1       user data accepted this cycle
//  ctrl_tdata_i      in   DATA_W  control message word
//  ctrl_tvalid_i     in   1       control valid
//  ctrl_tready_o     out  1       control accepted this cycle
//  tx_tdata_o        out  DATA_W  scheduled word (payload only; 0 for IDLE/FAW/CRC)
//  tx_type_o         out  3       0=IDLE 1=DATA 2=CTRL 3=FAW 4=CRC
//  tx_valid_o        out  1       tx_* holds a scheduled slot
//  state_o           out  2       0=DISABLED 1=WAIT_FAW 2=RUN
// BEHAVIOUR
//  Reset
//  - state=DISABLED; tx_tdata_o=0, tx_type_o=0, tx_valid_o=0.
//  - burst_cnt=0; all stat counters=0.
//  FSM
//  - DISABLED -> WAIT_FAW when enable_i=1.
//  - WAIT_FAW -> RUN on a cycle with faw_boundary_i=1 (that slot is scheduled as FAW).
//  - Any state -> DISABLED the cycle after enable_i=0.
//  Slot class, in RUN or on the WAIT_FAW->RUN cycle
//  - faw_boundary_i=1 -> FAW; this wins if faw_boundary_i and crc_boundary_i are both 1.
//  - else crc_boundary_i=1 -> CRC.
//  - else -> payload slot.
//  Payload slot arbitration
//  - ctrl granted if ctrl_tvalid_i and (burst_cnt<MAX_CTRL_BURST or !data_tvalid_i).
//  - else data granted if data_tvalid_i.
//  - else IDLE.
//  Handshake
//  - tready_o is combinational and asserted only for the granted stream (AXIS rules).
//  - Both readies are 0 in FAW/CRC slots, in DISABLED/WAIT_FAW, and whenever enable_i=0.
//  - A requester may hold tvalid across non-payload slots; its data must stay stable.
//  burst_cnt
//  - Increments (saturating at MAX_CTRL_BURST) on a ctrl grant while data_tvalid_i=1.
//  - Clears on a data grant, or on a payload slot with data_tvalid_i=0.
//  - Holds on FAW/CRC slots; clears in DISABLED.
//  Output timing
//  - tx_* registered, latency 1: slot at cycle t appears on tx_* at t+1.
//  - tx_valid_o=1 for every slot classified in RUN or on the entry cycle; otherwise 0.
//  Reset or disable mid-frame
//  - No partial words are emitted.
//  - Re-entry always waits for a fresh FAW.
// CONFIGURATION
//  QECIPHY_TX_SCHED_STATS_EN defined
//  - Adds outputs stat_data_cnt_o, stat_ctrl_cnt_o, stat_idle_cnt_o [STAT_W].
//  - Each counts DATA/CTRL/IDLE slots scheduled in RUN, wraps modulo 2^STAT_W.
//  - Counters clear on reset only.
//  Macro undefined
//  - Those ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset then enable_i=1, no FAW for 20 cycles -> state_o=1, tx_valid_o=0, both readies 0.
//  2. FAW at t0, CRC at t7 and t14, data_tvalid_i=1 constant ->
//     type 3 at t1; 1 at t2..t7; 4 at t8; 1 at t9..t14; 4 at t15.
//  3. RUN, both valid continuously, MAX_CTRL_BURST=4 -> payload grant pattern C,C,C,C,D repeating;
//     burst_cnt holds across CRC.
//  4. RUN, ctrl only valid -> every payload slot CTRL (no saturation stall); neither valid -> type 0.
//  5. enable_i=0 mid-frame -> readies 0 same cycle; state_o=0 next cycle.
//     Re-enable -> no grants until the next faw_boundary_i.
//  6. Stats build: 64-cycle frame with 1 FAW, 9 CRC, data always valid -> stat_data_cnt_o +=54 per frame.
//     FAW and CRC set together -> type 3.

Source files
------------

// File: rtl/qeciphy_tx_slot_scheduler.sv
// qeciphy_tx_slot_scheduler
//   Per-cycle TX slot scheduler feeding the TX framer mux. Every cycle is
//   classified as a FAW, CRC or payload slot from the boundary strobes.
//   Payload slots are arbitrated between the control and user-data streams,
//   with a bounded control burst while data is pending.
//   The scheduled word and its type code come out one cycle later.
//
//   Optional build macro: QECIPHY_TX_SCHED_STATS_EN
//     Adds DATA/CTRL/IDLE slot counters (stat_*_cnt_o, STAT_W bits wide,
//     wrapping, cleared on reset only).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   DISABLED | enable low; no slots scheduled, burst counter cleared
//   WAIT_FAW | enabled, waiting for a FAW boundary to align to the frame
//   RUN      | aligned; every cycle produces a FAW, CRC or payload slot
module qeciphy_tx_slot_scheduler #(
  parameter int DATA_W         = 64,
  parameter int MAX_CTRL_BURST = 4,
  parameter int STAT_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              faw_boundary_i,
  input  logic              crc_boundary_i,
  input  logic [DATA_W-1:0] data_tdata_i,
  input  logic              data_tvalid_i,
  output logic              data_tready_o,
  input  logic [DATA_W-1:0] ctrl_tdata_i,
  input  logic              ctrl_tvalid_i,
  output logic              ctrl_tready_o,
  output logic [DATA_W-1:0] tx_tdata_o,
  output logic [2:0]        tx_type_o,
  output logic              tx_valid_o,
`ifdef QECIPHY_TX_SCHED_STATS_EN
  output logic [STAT_W-1:0] stat_data_cnt_o,
  output logic [STAT_W-1:0] stat_ctrl_cnt_o,
  output logic [STAT_W-1:0] stat_idle_cnt_o,
`endif
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_WAIT_FAW = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  localparam logic [2:0] TYPE_IDLE = 3'd0;
  localparam logic [2:0] TYPE_DATA = 3'd1;
  localparam logic [2:0] TYPE_CTRL = 3'd2;
  localparam logic [2:0] TYPE_FAW  = 3'd3;
  localparam logic [2:0] TYPE_CRC  = 3'd4;

  localparam logic [3:0] BURST_MAX = 4'(MAX_CTRL_BURST);

  // Reject parameter values the 4-bit burst counter or stat counters cannot hold.
  if (MAX_CTRL_BURST < 1 || MAX_CTRL_BURST > 15 || STAT_W < 1) begin : g_param_check
    $error("qeciphy_tx_slot_scheduler: MAX_CTRL_BURST must be 1..15 and STAT_W >= 1");
  end

  state_t      state;
  state_t      state_next;
  logic [3:0]  burst_cnt;
  logic        slot_active;
  logic        slot_payload;
  logic        grant_ctrl;
  logic        grant_data;
  logic [2:0]  slot_type;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= ST_DISABLED;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: enable low always drops back to DISABLED; re-entry needs a fresh FAW.
  always_comb begin
    state_next = state;
    if (!enable_i) begin
      state_next = ST_DISABLED;
    end else begin
      case (state)
        ST_DISABLED: state_next = ST_WAIT_FAW;
        ST_WAIT_FAW: if (faw_boundary_i) state_next = ST_RUN;
        ST_RUN:      state_next = ST_RUN;
        default:     state_next = ST_DISABLED;
      endcase
    end
  end

  // Slot classification, arbitration and combinational handshakes.
  // The FAW that moves WAIT_FAW to RUN is itself scheduled.
  always_comb begin
    slot_active  = enable_i &&
                   ((state == ST_RUN) || ((state == ST_WAIT_FAW) && faw_boundary_i));
    slot_payload = slot_active && !faw_boundary_i && !crc_boundary_i;
    grant_ctrl   = slot_payload && ctrl_tvalid_i &&
                   ((burst_cnt < BURST_MAX) || !data_tvalid_i);
    grant_data   = slot_payload && !grant_ctrl && data_tvalid_i;

    slot_type = TYPE_IDLE;
    if (slot_active) begin
      if (faw_boundary_i)      slot_type = TYPE_FAW;
      else if (crc_boundary_i) slot_type = TYPE_CRC;
      else if (grant_ctrl)     slot_type = TYPE_CTRL;
      else if (grant_data)     slot_type = TYPE_DATA;
      else                     slot_type = TYPE_IDLE;
    end

    data_tready_o = grant_data;
    ctrl_tready_o = grant_ctrl;
    state_o       = state;
  end

  // Registered slot output: whole words only, zero for non-payload slots.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tx_valid_o <= 1'b0;
      tx_type_o  <= TYPE_IDLE;
      tx_tdata_o <= '0;
    end else begin
      tx_valid_o <= slot_active;
      tx_type_o  <= slot_type;
      if (grant_ctrl)      tx_tdata_o <= ctrl_tdata_i;
      else if (grant_data) tx_tdata_o <= data_tdata_i;
      else                 tx_tdata_o <= '0;
    end
  end

  // Consecutive ctrl grants while data waits; held across FAW/CRC slots.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || (state == ST_DISABLED)) begin
      burst_cnt <= '0;
    end else if (grant_data) begin
      burst_cnt <= '0;
    end else if (grant_ctrl && data_tvalid_i) begin
      if (burst_cnt < BURST_MAX) burst_cnt <= burst_cnt + 4'd1;
    end else if (slot_payload && !data_tvalid_i) begin
      burst_cnt <= '0;
    end
  end

`ifdef QECIPHY_TX_SCHED_STATS_EN
  // Payload slot statistics; only a reset clears them.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stat_data_cnt_o <= '0;
      stat_ctrl_cnt_o <= '0;
      stat_idle_cnt_o <= '0;
    end else if (slot_payload && (state == ST_RUN)) begin
      if (grant_ctrl)      stat_ctrl_cnt_o <= stat_ctrl_cnt_o + 1'b1;
      else if (grant_data) stat_data_cnt_o <= stat_data_cnt_o + 1'b1;
      else                 stat_idle_cnt_o <= stat_idle_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_qeciphy_tx_slot_scheduler.sv
// Bench for qeciphy_tx_slot_scheduler: directed scenarios with literal
// expectations plus a long randomized run against a slot-level model.
module tb_qeciphy_tx_slot_scheduler;
  localparam int DW = 64;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, faw = 1'b0, crc = 1'b0;
  logic [DW-1:0] dd = '0, cd = '0;
  logic          dv = 1'b0, cv = 1'b0;
  logic          data_rdy, ctrl_rdy;
  logic [DW-1:0] tx_data;
  logic [2:0]    tx_type;
  logic          tx_valid;
  logic [1:0]    state;
`ifdef QECIPHY_TX_SCHED_STATS_EN
  logic [31:0]   st_data, st_ctrl, st_idle;
  int            m_sd = 0, m_sc = 0, m_si = 0;
`endif

  qeciphy_tx_slot_scheduler #(.DATA_W(DW), .MAX_CTRL_BURST(MB), .STAT_W(32)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .enable_i       (en),
    .faw_boundary_i (faw),
    .crc_boundary_i (crc),
    .data_tdata_i   (dd),
    .data_tvalid_i  (dv),
    .data_tready_o  (data_rdy),
    .ctrl_tdata_i   (cd),
    .ctrl_tvalid_i  (cv),
    .ctrl_tready_o  (ctrl_rdy),
    .tx_tdata_o     (tx_data),
    .tx_type_o      (tx_type),
    .tx_valid_o     (tx_valid),
`ifdef QECIPHY_TX_SCHED_STATS_EN
    .stat_data_cnt_o(st_data),
    .stat_ctrl_cnt_o(st_ctrl),
    .stat_idle_cnt_o(st_idle),
`endif
    .state_o        (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: mode 0=disabled 1=waiting for FAW 2=running; burst = ctrl run length.
  int            m_mode = 0, m_burst = 0;
  logic          m_valid = 1'b0;
  logic [2:0]    m_type = 3'd0;
  logic [DW-1:0] m_data = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_burst = 0; m_valid = 1'b0; m_type = 3'd0; m_data = '0;
`ifdef QECIPHY_TX_SCHED_STATS_EN
    m_sd = 0; m_sc = 0; m_si = 0;
`endif
  endtask

  // One cycle: drive, check handshakes, clock, check scheduled slot.
  // Sources follow AXIS: a valid word is held unchanged until accepted.
  task automatic step(input logic e, input logic f, input logic c, input int pd, input int pc);
    logic act, pay, gd, gc;
    logic [2:0] t;
    en = e; faw = f; crc = c;
    if (!dv && $urandom_range(99) < pd) begin dv = 1'b1; dd = {$urandom, $urandom}; end
    if (!cv && $urandom_range(99) < pc) begin cv = 1'b1; cd = {$urandom, $urandom}; end
    act = e && (m_mode == 2 || (m_mode == 1 && f));
    pay = act && !f && !c;
    gc  = pay && cv && (m_burst < MB || !dv);
    gd  = pay && !gc && dv;
    if (!act)    t = 3'd0;
    else if (f)  t = 3'd3;
    else if (c)  t = 3'd4;
    else if (gc) t = 3'd2;
    else if (gd) t = 3'd1;
    else         t = 3'd0;
    #2;
    chk("data_tready", {63'd0, data_rdy}, {63'd0, gd});
    chk("ctrl_tready", {63'd0, ctrl_rdy}, {63'd0, gc});
    chk("state", {62'd0, state}, DW'(m_mode));
    @(posedge clk);
    #1;
    m_valid = act;
    m_type  = t;
    m_data  = gc ? cd : (gd ? dd : '0);
`ifdef QECIPHY_TX_SCHED_STATS_EN
    if (pay && m_mode == 2) begin
      if (gc) m_sc++; else if (gd) m_sd++; else m_si++;
    end
`endif
    if (m_mode == 0)       m_burst = 0;
    else if (gd)           m_burst = 0;
    else if (gc && dv)     m_burst = (m_burst < MB) ? m_burst + 1 : MB;
    else if (pay && !dv)   m_burst = 0;
    if (!e)                        m_mode = 0;
    else if (m_mode == 0)          m_mode = 1;
    else if (m_mode == 1 && f)     m_mode = 2;
    if (gd) dv = 1'b0;
    if (gc) cv = 1'b0;
    chk("tx_valid", {63'd0, tx_valid}, {63'd0, m_valid});
    chk("tx_type", {61'd0, tx_type}, {61'd0, m_type});
    chk("tx_tdata", tx_data, m_data);
`ifdef QECIPHY_TX_SCHED_STATS_EN
    chk("stat_data", {32'd0, st_data}, DW'(m_sd));
    chk("stat_ctrl", {32'd0, st_ctrl}, DW'(m_sc));
    chk("stat_idle", {32'd0, st_idle}, DW'(m_si));
`endif
  endtask

  initial begin
    logic [47:0] seq_act, seq_exp;
    logic [44:0] pat_act, pat_exp;
    int n, cnt;
`ifdef QECIPHY_TX_SCHED_STATS_EN
    int sd0;
`endif

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_tx_type", {61'd0, tx_type}, 64'd0);
    chk("rst_tx_tdata", tx_data, 64'd0);
    chk("rst_state", {62'd0, state}, 64'd0);
    rst_n = 1'b1;
    model_reset();

    // Enabled without FAW: stays in WAIT_FAW, nothing scheduled.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 100, 0);
    chk("wait_state", {62'd0, state}, 64'd1);
    chk("wait_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("wait_data_rdy", {63'd0, data_rdy}, 64'd0);

    // FAW at t0, CRC at t7 and t14, data always valid.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, (i == 7 || i == 14), 100, 0);
      seq_act[i*3 +: 3] = tx_type;
      seq_exp[i*3 +: 3] = (i == 0) ? 3'd3 : ((i == 7 || i == 14) ? 3'd4 : 3'd1);
    end
    chk("frame_types", {16'd0, seq_act}, {16'd0, seq_exp});

    // Both streams valid: C,C,C,C,D with the count held across a CRC.
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, i == 2, 100, 100);
      if (i != 2) begin
        pat_act[n*3 +: 3] = tx_type;
        pat_exp[n*3 +: 3] = (n % 5 == 4) ? 3'd1 : 3'd2;
        n++;
      end
    end
    chk("burst_pattern", {19'd0, pat_act}, {19'd0, pat_exp});

    // Ctrl only: every payload slot is CTRL; then nothing valid: IDLE.
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 0, 100);
      if (i >= 4 && tx_type == 3'd2) cnt++;
    end
    chk("ctrl_only_cnt", DW'(cnt), 64'd6);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    chk("idle_type", {61'd0, tx_type}, 64'd0);
    chk("idle_valid", {63'd0, tx_valid}, 64'd1);

    // Disable mid-frame, re-enable: nothing until a fresh FAW (here with CRC too).
    step(1'b1, 1'b0, 1'b0, 100, 100);
    step(1'b0, 1'b0, 1'b0, 100, 100);
    chk("dis_state", {62'd0, state}, 64'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 100, 100);
      if (tx_valid) cnt++;
    end
    chk("reenable_no_slots", DW'(cnt), 64'd0);
    step(1'b1, 1'b1, 1'b1, 100, 100);
    chk("faw_crc_type", {61'd0, tx_type}, 64'd3);
    chk("faw_crc_valid", {63'd0, tx_valid}, 64'd1);

`ifdef QECIPHY_TX_SCHED_STATS_EN
    // 64-slot frame: 1 FAW, 9 CRC, data always valid -> 54 data slots.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 100, 0);
    sd0 = int'(st_data);
    for (int i = 0; i < 64; i++) step(1'b1, i == 0, (i % 7 == 0) && i != 0, 100, 0);
    chk("stat_frame_data", DW'(int'(st_data) - sd0), 64'd54);
`endif

    // Randomized run with an occasional mid-run reset.
    for (int blk = 0; blk < 30; blk++) begin
      int pd, pc;
      pd = $urandom_range(90, 10);
      pc = $urandom_range(90, 10);
      if (blk == 15) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_state", {62'd0, state}, 64'd0);
        chk("midrst_valid", {63'd0, tx_valid}, 64'd0);
        rst_n = 1'b1;
        model_reset();
      end
      for (int i = 0; i < 100; i++)
        step($urandom_range(99) < 97, $urandom_range(15) == 0, $urandom_range(9) == 0, pd, pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
